fetch_issue_queue: RTL and testbench

Receiving end of the fetch-to-decode instruction pair interface. Accepts up to two instructions per cycle from the fetch stage into a circular buffer. Returns back-pressure (`stall`) when fewer than two entries are free. Presents the two oldest instructions, first-word-fall-through, to the decode/dispatch stage under a per-slot valid/ready handshake; `flush` discards everything on a branch redirect.

---
 rtl/fetch_issue_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_issue_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode instruction pair queue: two-wide enqueue, two-wide FWFT dequeue, flush on redirect.
// Optional FETCH_IQ_PERF_CNT_EN adds stall/empty cycle counters.
module fetch_issue_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid1,
  input  logic            in_valid2,
  input  logic [XLEN-1:0] in_instr1,
  input  logic [XLEN-1:0] in_instr2,
  input  logic [XLEN-1:0] in_pc,
  output logic            stall,
  output logic            out_valid1,
  output logic            out_valid2,
  output logic [XLEN-1:0] out_instr1,
  output logic [XLEN-1:0] out_instr2,
  output logic [XLEN-1:0] out_pc1,
  output logic [XLEN-1:0] out_pc2,
  input  logic            out_ready1,
  input  logic            out_ready2
`ifdef FETCH_IQ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_empty_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pc_mem_d    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    enq, deq;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Fewer than two free entries means count exceeds DEPTH-2; registered count only.
  assign stall      = count_q > CW'(DEPTH - 2);
  assign out_valid1 = count_q != '0;
  assign out_valid2 = count_q > CW'(1);

  always_comb begin
    out_instr1 = '0;
    out_pc1    = '0;
    out_instr2 = '0;
    out_pc2    = '0;
    if (out_valid1) begin
      out_instr1 = instr_mem_q[head_q];
      out_pc1    = pc_mem_q[head_q];
    end
    if (out_valid2) begin
      out_instr2 = instr_mem_q[head_p1];
      out_pc2    = pc_mem_q[head_p1];
    end
  end

  always_comb begin
    enq = '0;
    deq = '0;
    if (!flush && !stall && in_valid1) begin
      enq = in_valid2 ? 2'd2 : 2'd1;
    end
    if (!flush) begin
      deq = {1'b0, out_valid1 & out_ready1} + {1'b0, out_valid2 & out_ready2 & out_ready1};
    end

    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (enq != 2'd0) begin
      instr_mem_d[tail_q] = in_instr1;
      pc_mem_d[tail_q]    = in_pc;
    end
    if (enq == 2'd2) begin
      instr_mem_d[tail_p1] = in_instr2;
      pc_mem_d[tail_p1]    = in_pc + XLEN'(4);
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq);
      tail_d  = tail_q + AW'(enq);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

`ifdef FETCH_IQ_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_empty_d = perf_empty_q;
    if (stall && in_valid1) perf_stall_d = perf_stall_q + 32'd1;
    if (count_q == '0)      perf_empty_d = perf_empty_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed self-checking bench for fetch_issue_queue (DEPTH=8, XLEN=32).
module tb_fetch_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid1, in_valid2;
  logic [31:0] in_instr1, in_instr2, in_pc;
  logic        stall;
  logic        out_valid1, out_valid2;
  logic [31:0] out_instr1, out_instr2, out_pc1, out_pc2;
  logic        out_ready1, out_ready2;
`ifdef FETCH_IQ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_empty_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_issue_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid1  (in_valid1),
    .in_valid2  (in_valid2),
    .in_instr1  (in_instr1),
    .in_instr2  (in_instr2),
    .in_pc      (in_pc),
    .stall      (stall),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_instr1 (out_instr1),
    .out_instr2 (out_instr2),
    .out_pc1    (out_pc1),
    .out_pc2    (out_pc2),
    .out_ready1 (out_ready1),
    .out_ready2 (out_ready2)
`ifdef FETCH_IQ_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic v2, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] pc);
    in_valid1 = v1;
    in_valid2 = v2;
    in_instr1 = i1;
    in_instr2 = i2;
    in_pc     = pc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;
    idle_in();
    #2;
    check("rst_valid1", {31'b0, out_valid1}, 32'd0);
    check("rst_valid2", {31'b0, out_valid2}, 32'd0);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_instr1", out_instr1, 32'd0);
    check("rst_pc1",    out_pc1, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valid1", {31'b0, out_valid1}, 32'd0);
      check("idle_valid2", {31'b0, out_valid2}, 32'd0);
      check("idle_stall",  {31'b0, stall}, 32'd0);
      check("idle_instr1", out_instr1, 32'd0);
    end
`ifdef FETCH_IQ_PERF_CNT_EN
    check("perf_empty_idle", perf_empty_cycles, 32'd10);
`endif

    // Single pair push, no ready
    drive(1'b1, 1'b1, 32'h00A00093, 32'h00B00113, 32'h100);
    tick();
    idle_in();
    check("pair_valid1", {31'b0, out_valid1}, 32'd1);
    check("pair_valid2", {31'b0, out_valid2}, 32'd1);
    check("pair_pc1",    out_pc1, 32'h100);
    check("pair_pc2",    out_pc2, 32'h104);
    check("pair_instr1", out_instr1, 32'h00A00093);
    check("pair_instr2", out_instr2, 32'h00B00113);
    out_ready1 = 1'b1;
    out_ready2 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;
    check("pair_drained", {31'b0, out_valid1}, 32'd0);

    // Fill to DEPTH with four pairs; stall once fewer than two entries free
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h10 + 32'(2*k), 32'h11 + 32'(2*k), 32'h200 + 32'(8*k));
      tick();
      check("fill_stall", {31'b0, stall}, (k == 3) ? 32'd1 : 32'd0);
    end
    check("fill_head", out_instr1, 32'h10);
    check("fill_head2", out_instr2, 32'h11);
    drive(1'b1, 1'b1, 32'hEE, 32'hEF, 32'h900);
    tick();
    idle_in();
    check("full_ignored_stall", {31'b0, stall}, 32'd1);
    check("full_ignored_head", out_instr1, 32'h10);
`ifdef FETCH_IQ_PERF_CNT_EN
    check("perf_stall", perf_stall_cycles, 32'd1);
`endif
    out_ready1 = 1'b1;
    tick();
    check("deq1_stall", {31'b0, stall}, 32'd1);
    check("deq1_head",  out_instr1, 32'h11);
    check("deq1_head2", out_instr2, 32'h12);
    tick();
    check("deq2_stall", {31'b0, stall}, 32'd0);
    check("deq2_head",  out_instr1, 32'h12);
    check("deq2_pc",    out_pc1, 32'h208);
    out_ready2 = 1'b1;
    tick();
    check("drain_a", out_instr1, 32'h14);
    tick();
    check("drain_b", out_instr1, 32'h16);
    check("drain_b2", out_instr2, 32'h17);
    check("drain_b_pc2", out_pc2, 32'h21C);
    tick();
    check("drain_empty", {31'b0, out_valid1}, 32'd0);
    check("drain_empty_instr", out_instr1, 32'd0);

    // Streaming wrap-around with both readies held high
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'(2*i), 32'(2*i+1), 32'h1000 + 32'(8*i));
      tick();
      check("stream_v1",  {31'b0, out_valid1}, 32'd1);
      check("stream_v2",  {31'b0, out_valid2}, 32'd1);
      check("stream_i1",  out_instr1, 32'(2*i));
      check("stream_i2",  out_instr2, 32'(2*i+1));
      check("stream_pc1", out_pc1, 32'h1000 + 32'(8*i));
      check("stream_pc2", out_pc2, 32'h1004 + 32'(8*i));
      check("stream_stall", {31'b0, stall}, 32'd0);
    end
    idle_in();
    tick();
    check("stream_empty", {31'b0, out_valid1}, 32'd0);
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;

    // Flush with five entries and simultaneous enqueue/dequeue
    drive(1'b1, 1'b1, 32'h50, 32'h51, 32'h400);
    tick();
    drive(1'b1, 1'b1, 32'h52, 32'h53, 32'h408);
    tick();
    drive(1'b1, 1'b0, 32'h54, 32'h0, 32'h410);
    tick();
    check("preflush_head", out_instr1, 32'h50);
    flush = 1'b1;
    out_ready1 = 1'b1;
    drive(1'b1, 1'b0, 32'h99, 32'h0, 32'h500);
    tick();
    flush = 1'b0;
    out_ready1 = 1'b0;
    idle_in();
    check("flush_valid1", {31'b0, out_valid1}, 32'd0);
    check("flush_stall",  {31'b0, stall}, 32'd0);
    drive(1'b1, 1'b0, 32'h77, 32'h0, 32'h300);
    tick();
    idle_in();
    check("postflush_v1",  {31'b0, out_valid1}, 32'd1);
    check("postflush_v2",  {31'b0, out_valid2}, 32'd0);
    check("postflush_i1",  out_instr1, 32'h77);
    check("postflush_pc1", out_pc1, 32'h300);
    check("postflush_i2",  out_instr2, 32'd0);
    check("postflush_pc2", out_pc2, 32'd0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("postflush_empty", {31'b0, out_valid1}, 32'd0);

    // Orphan in_valid2 and out_ready2 are ignored
    drive(1'b0, 1'b1, 32'h0, 32'h66, 32'h600);
    tick();
    idle_in();
    check("orphan_v2_in", {31'b0, out_valid1}, 32'd0);
    drive(1'b1, 1'b1, 32'h88, 32'h89, 32'h700);
    tick();
    idle_in();
    out_ready2 = 1'b1;
    tick();
    check("orphan_rdy2_v2", {31'b0, out_valid2}, 32'd1);
    check("orphan_rdy2_i1", out_instr1, 32'h88);
    out_ready2 = 1'b0;

    // Asynchronous reset mid-operation
    #2 reset = 1'b1;
    #1;
    check("async_rst_v1", {31'b0, out_valid1}, 32'd0);
    check("async_rst_i1", out_instr1, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("after_rst_v1", {31'b0, out_valid1}, 32'd0);
    check("after_rst_stall", {31'b0, stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
